// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, absorbs the ROM's one-cycle read latency, valid/ready to decode.
// Optional FETCH_JMP_PREDECODE_EN: accepted JMP words redirect the PC to their own target field.
module fetch_unit #(
    parameter logic [9:0] RESET_PC = 10'd0
) (
    input  logic        clk,
    input  logic        reset,
    output logic [9:0]  pc,
    input  logic [15:0] rom_instr,
    input  logic        jump_en,
    input  logic [9:0]  jump_addr,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [15:0] instr,
    output logic [9:0]  instr_pc
);

`ifdef FETCH_JMP_PREDECODE_EN
`ifndef JMP
`define JMP 6'h3f
`endif
    localparam logic [5:0] JMP_OP = `JMP;
`endif

    logic [9:0]  pc_q;
    logic        inflight;
    logic [9:0]  inflight_pc;
    logic        hold_valid;
    logic [15:0] hold_instr;
    logic [9:0]  hold_pc;

    logic        issue;
    logic        redirect;
    logic [9:0]  redirect_addr;

    assign pc = pc_q;

    always_comb begin
        instr_valid = 1'b0;
        instr       = '0;
        instr_pc    = '0;
        if (hold_valid) begin
            instr_valid = 1'b1;
            instr       = hold_instr;
            instr_pc    = hold_pc;
        end else if (inflight) begin
            instr_valid = 1'b1;
            instr       = rom_instr;
            instr_pc    = inflight_pc;
        end
    end

    assign issue = !instr_valid || instr_ready;

    always_comb begin
        redirect      = jump_en;
        redirect_addr = jump_addr;
`ifdef FETCH_JMP_PREDECODE_EN
        if (!jump_en && instr_valid && instr_ready && (instr[15:10] == JMP_OP)) begin
            redirect      = 1'b1;
            redirect_addr = instr[9:0];
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q        <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            hold_valid  <= 1'b0;
            hold_instr  <= '0;
            hold_pc     <= '0;
        end else if (redirect) begin
            // The word the ROM samples at this edge belongs to the old stream; drop it.
            pc_q       <= redirect_addr;
            inflight   <= 1'b0;
            hold_valid <= 1'b0;
        end else begin
            if (issue) begin
                inflight    <= 1'b1;
                inflight_pc <= pc_q;
                pc_q        <= pc_q + 10'd1;
            end else begin
                inflight <= 1'b0;
            end
            if (inflight && !hold_valid && !instr_ready) begin
                hold_valid <= 1'b1;
                hold_instr <= rom_instr;
                hold_pc    <= inflight_pc;
            end else if (hold_valid && instr_ready) begin
                hold_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: registered ROM model, directed scenarios and a randomized stream.
`ifndef JMP
`define JMP 6'h3f
`endif
module tb_fetch_unit;

    localparam logic [5:0] JMP_OP = `JMP;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [9:0]  pc;
    logic [15:0] rom_instr;
    logic        jump_en = 1'b0;
    logic [9:0]  jump_addr = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b1;
    logic [15:0] instr;
    logic [9:0]  instr_pc;

    logic [15:0] rom [1024];

    int checks = 0;
    int failures = 0;

    logic        o_valid;
    logic [15:0] o_instr;
    logic [9:0]  o_ipc;
    logic [9:0]  o_pc;

    fetch_unit #(.RESET_PC(10'd0)) dut (
        .clk        (clk),
        .reset      (reset),
        .pc         (pc),
        .rom_instr  (rom_instr),
        .jump_en    (jump_en),
        .jump_addr  (jump_addr),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .instr      (instr),
        .instr_pc   (instr_pc)
    );

    always #5 clk = ~clk;

    // Synchronous ROM: address sampled at posedge, data one cycle later.
    always @(posedge clk) rom_instr <= rom[pc];

    task automatic step(input logic rdy, input logic jen, input logic [9:0] ja, input logic rst);
        @(negedge clk);
        reset       = rst;
        instr_ready = rdy;
        jump_en     = jen;
        jump_addr   = ja;
        #1;
        o_valid = instr_valid;
        o_instr = instr;
        o_ipc   = instr_pc;
        o_pc    = pc;
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, '0, 1'b1);
        step(1'b1, 1'b0, '0, 1'b1);
        step(1'b1, 1'b0, '0, 1'b0);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, '0, 1'b1);
            checks++;
            if (o_pc !== 10'd0 || o_valid !== 1'b0 || o_instr !== 16'h0 || o_ipc !== 10'd0) begin
                failures++;
                $display("FAIL reset_hold: pc=%0d valid=%b instr=%h ipc=%0d, need 0/0/0000/0", o_pc, o_valid, o_instr, o_ipc);
            end
        end
        step(1'b1, 1'b0, '0, 1'b0);
        checks++;
        if (o_pc !== 10'd0 || o_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_first_cycle: pc=%0d valid=%b, need 0/0", o_pc, o_valid);
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, '0, 1'b0);
            checks++;
            if (o_valid !== 1'b1 || o_ipc !== 10'(i) || o_instr !== rom[i]) begin
                failures++;
                $display("FAIL reset_seq: valid=%b ipc=%0d instr=%h, need 1/%0d/%h", o_valid, o_ipc, o_instr, i, rom[i]);
            end
        end
    endtask

    task automatic test_stall();
        logic [15:0] w;
        logic [9:0]  q [$];
        int gaps;
        do_reset();
        step(1'b1, 1'b0, '0, 1'b0);
        step(1'b1, 1'b0, '0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0);
        w = rom[2];
        checks++;
        if (o_valid !== 1'b1 || o_ipc !== 10'd2 || o_instr !== w || o_pc !== 10'd3) begin
            failures++;
            $display("FAIL stall_start: valid=%b ipc=%0d instr=%h pc=%0d, need 1/2/%h/3", o_valid, o_ipc, o_instr, o_pc, w);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, '0, 1'b0);
            checks++;
            if (o_valid !== 1'b1 || o_ipc !== 10'd2 || o_instr !== w || o_pc !== 10'd3) begin
                failures++;
                $display("FAIL stall_hold: valid=%b ipc=%0d instr=%h pc=%0d, need 1/2/%h/3", o_valid, o_ipc, o_instr, o_pc, w);
            end
        end
        step(1'b1, 1'b0, '0, 1'b0);
        checks++;
        if (o_valid !== 1'b1 || o_ipc !== 10'd2 || o_instr !== w) begin
            failures++;
            $display("FAIL stall_release: valid=%b ipc=%0d instr=%h, need 1/2/%h", o_valid, o_ipc, o_instr, w);
        end
        gaps = 0;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, '0, 1'b0);
            if (o_valid) q.push_back(o_ipc);
            else gaps++;
        end
        checks++;
        if (q.size() < 3 || q[0] !== 10'd3 || q[1] !== 10'd4 || q[2] !== 10'd5 || gaps > 1) begin
            failures++;
            $display("FAIL stall_resume: got %0d words first=%0d gaps=%0d, need 3,4,5 with <=1 gap", q.size(), (q.size() > 0) ? q[0] : 10'h3ff, gaps);
        end
    endtask

    task automatic test_jump();
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, '0, 1'b0);
        step(1'b1, 1'b1, 10'd3, 1'b0);
        checks++;
        if (o_valid !== 1'b1 || o_ipc !== 10'd5) begin
            failures++;
            $display("FAIL jump_presented: valid=%b ipc=%0d, need 1/5", o_valid, o_ipc);
        end
        step(1'b1, 1'b0, '0, 1'b0);
        checks++;
        if (o_valid !== 1'b0 || o_pc !== 10'd3) begin
            failures++;
            $display("FAIL jump_bubble: valid=%b pc=%0d, need 0/3", o_valid, o_pc);
        end
        for (int i = 3; i < 5; i++) begin
            step(1'b1, 1'b0, '0, 1'b0);
            checks++;
            if (o_valid !== 1'b1 || o_ipc !== 10'(i) || o_instr !== rom[i]) begin
                failures++;
                $display("FAIL jump_target: valid=%b ipc=%0d instr=%h, need 1/%0d/%h", o_valid, o_ipc, o_instr, i, rom[i]);
            end
        end
    endtask

    task automatic test_wrap();
        logic [9:0] a;
        do_reset();
        step(1'b1, 1'b1, 10'd1023, 1'b0);
        step(1'b1, 1'b0, '0, 1'b0);
        checks++;
        if (o_valid !== 1'b0 || o_pc !== 10'd1023) begin
            failures++;
            $display("FAIL wrap_bubble: valid=%b pc=%0d, need 0/1023", o_valid, o_pc);
        end
        a = 10'd1023;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, '0, 1'b0);
            checks++;
            if (o_valid !== 1'b1 || o_ipc !== a || o_instr !== rom[a]) begin
                failures++;
                $display("FAIL wrap_seq: valid=%b ipc=%0d instr=%h, need 1/%0d/%h", o_valid, o_ipc, o_instr, a, rom[a]);
            end
            a = a + 10'd1;
        end
    endtask

    task automatic test_reset_hold();
        do_reset();
        step(1'b1, 1'b0, '0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0);
        checks++;
        if (o_valid !== 1'b1 || o_ipc !== 10'd1) begin
            failures++;
            $display("FAIL rsthold_held: valid=%b ipc=%0d, need 1/1", o_valid, o_ipc);
        end
        step(1'b1, 1'b0, '0, 1'b1);
        step(1'b1, 1'b0, '0, 1'b0);
        checks++;
        if (o_valid !== 1'b0 || o_pc !== 10'd0) begin
            failures++;
            $display("FAIL rsthold_cleared: valid=%b pc=%0d, need 0/0", o_valid, o_pc);
        end
        step(1'b1, 1'b0, '0, 1'b0);
        checks++;
        if (o_valid !== 1'b1 || o_ipc !== 10'd0 || o_instr !== rom[0]) begin
            failures++;
            $display("FAIL rsthold_restart: valid=%b ipc=%0d instr=%h, need 1/0/%h", o_valid, o_ipc, o_instr, rom[0]);
        end
    endtask

    task automatic test_predecode();
        logic [15:0] saved;
        logic [15:0] jw;
        saved   = rom[5];
        jw      = {JMP_OP, 10'd3};
        rom[5]  = jw;
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, '0, 1'b0);
        step(1'b1, 1'b0, '0, 1'b0);
        checks++;
        if (o_valid !== 1'b1 || o_ipc !== 10'd5 || o_instr !== jw) begin
            failures++;
            $display("FAIL predecode_word: valid=%b ipc=%0d instr=%h, need 1/5/%h", o_valid, o_ipc, o_instr, jw);
        end
`ifdef FETCH_JMP_PREDECODE_EN
        step(1'b1, 1'b0, '0, 1'b0);
        checks++;
        if (o_valid !== 1'b0 || o_pc !== 10'd3) begin
            failures++;
            $display("FAIL predecode_bubble: valid=%b pc=%0d, need 0/3", o_valid, o_pc);
        end
        step(1'b1, 1'b0, '0, 1'b0);
        checks++;
        if (o_valid !== 1'b1 || o_ipc !== 10'd3) begin
            failures++;
            $display("FAIL predecode_target: valid=%b ipc=%0d, need 1/3", o_valid, o_ipc);
        end
`else
        for (int i = 6; i < 8; i++) begin
            step(1'b1, 1'b0, '0, 1'b0);
            checks++;
            if (o_valid !== 1'b1 || o_ipc !== 10'(i)) begin
                failures++;
                $display("FAIL predecode_passthru: valid=%b ipc=%0d, need 1/%0d", o_valid, o_ipc, i);
            end
        end
`endif
        rom[5] = saved;
    endtask

    task automatic test_random();
        logic [9:0]  exp_next;
        logic        rdy, jen, prev_jen, prev_stall;
        logic [9:0]  ja, prev_ja, prev_ipc;
        logic [15:0] prev_instr;
        int gap, accepted;
        do_reset();
        exp_next = 10'd0;
        prev_jen = 1'b0;
        prev_stall = 1'b0;
        prev_ja = '0;
        prev_ipc = '0;
        prev_instr = '0;
        gap = 0;
        accepted = 0;
        for (int c = 0; c < 500; c++) begin
            rdy = ($urandom_range(0, 9) < 7);
            jen = ($urandom_range(0, 19) == 0);
            ja  = 10'($urandom_range(0, 1023));
            step(rdy, jen, ja, 1'b0);
            if (prev_jen) begin
                checks++;
                if (o_valid !== 1'b0 || o_pc !== prev_ja) begin
                    failures++;
                    $display("FAIL rnd_jump_bubble: cyc=%0d valid=%b pc=%0d, need 0/%0d", c, o_valid, o_pc, prev_ja);
                end
            end
            if (!o_valid) begin
                checks++;
                if (o_instr !== 16'h0 || o_ipc !== 10'd0) begin
                    failures++;
                    $display("FAIL rnd_idle_zero: cyc=%0d instr=%h ipc=%0d, need 0000/0", c, o_instr, o_ipc);
                end
            end
            if (prev_stall) begin
                checks++;
                if (o_valid !== 1'b1 || o_ipc !== prev_ipc || o_instr !== prev_instr) begin
                    failures++;
                    $display("FAIL rnd_stable: cyc=%0d valid=%b ipc=%0d instr=%h, need 1/%0d/%h", c, o_valid, o_ipc, o_instr, prev_ipc, prev_instr);
                end
            end
            if (o_valid && rdy && !jen) begin
                checks++;
                if (o_ipc !== exp_next || o_instr !== rom[exp_next]) begin
                    failures++;
                    $display("FAIL rnd_accept: cyc=%0d ipc=%0d instr=%h, need %0d/%h", c, o_ipc, o_instr, exp_next, rom[exp_next]);
                end
                exp_next = exp_next + 10'd1;
                accepted++;
            end
            if (jen) exp_next = ja;
            if (o_valid || jen) gap = 0;
            else gap++;
            checks++;
            if (gap > 1) begin
                failures++;
                $display("FAIL rnd_gap: cyc=%0d gap=%0d, need <=1", c, gap);
            end
            prev_stall = o_valid && !rdy && !jen;
            prev_jen   = jen;
            prev_ja    = ja;
            prev_ipc   = o_ipc;
            prev_instr = o_instr;
        end
        checks++;
        if (accepted < 100) begin
            failures++;
            $display("FAIL rnd_throughput: accepted=%0d, need >=100", accepted);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            rom[i] = 16'($urandom);
`ifdef FETCH_JMP_PREDECODE_EN
            if (rom[i][15:10] == JMP_OP) rom[i][15] = ~rom[i][15];
`endif
        end
        @(posedge clk);
        test_reset();
        test_stall();
        test_jump();
        test_wrap();
        test_reset_hold();
        test_predecode();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
